com_bus_arbiter_i: RTL
======================

COM_BUS_ARBITER_I -- requirements
Module: com_bus_arbiter_I

Interface
REQ-001 Parameter NUM_REQ, default 4: number of cache requesters on the common instruction bus.
REQ-002 Parameter MAX_TENURE, default 16: maximum grant cycles while another requester is waiting.
REQ-003 clk  input  1  single clock, all state updates on posedge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 Com_Bus_Req_proc  input  NUM_REQ  per-cache bus request, level-held until service completes.
REQ-006 Com_Bus_Gnt_proc  output  NUM_REQ  per-cache grant, registered, at most one bit high.
REQ-007 Gnt_id  output  2  index of current grantee; valid only while Bus_busy=1.
REQ-008 Bus_busy  output  1  high while any grant is active.
REQ-009 Tenure_expired  output  1  one-cycle pulse when a grant is revoked by the tenure limit.

Function
REQ-010 FSM SHALL have three states: IDLE, GRANT, TURN.
REQ-011 IDLE: any request bit sampled high at edge k -> GRANT; the winner's Gnt bit is high after edge k (1-cycle latency).
REQ-012 Winner: round-robin; search starts at rr_ptr and wraps 3->0; rr_ptr updates to (winner+1) mod NUM_REQ on each new grant.
REQ-013 GRANT: grant held while the grantee's request stays high; all other request bits ignored.
REQ-014 Grantee request sampled low at edge m -> all Gnt bits low after m, state TURN.
REQ-015 TURN lasts exactly one cycle with no grant (bus turnaround); at its closing edge: if any request is high, grant the round-robin winner directly (-> GRANT); otherwise -> IDLE.
REQ-016 Tenure counter: 5-bit, cleared on each new grant, increments each cycle in GRANT, saturates at MAX_TENURE-1.
REQ-017 If counter = MAX_TENURE-1 and the grantee request is still high and any other request bit is high: revoke grant, pulse Tenure_expired for one cycle, -> TURN.
REQ-018 If counter is saturated and no other request is pending: grant SHALL be held; revoke when another request appears (evaluated each cycle).
REQ-019 Simultaneous grantee release and tenure expiry at the same edge: treat as a normal release; Tenure_expired stays low.
REQ-020 A requester revoked by tenure that keeps its request high competes again in TURN with round-robin priority (it is now lowest).
REQ-021 Com_Bus_Gnt_proc SHALL be one-hot or zero in every cycle; Gnt_id = encoded index of the high bit; Bus_busy = OR of Gnt bits.

Reset
REQ-022 rst_n low SHALL immediately force state IDLE, Com_Bus_Gnt_proc=0, Gnt_id=0, Bus_busy=0, Tenure_expired=0, rr_ptr=0, counter=0.
REQ-023 Reset asserted mid-grant SHALL drop the grant asynchronously; first arbitration occurs at the first posedge after rst_n deasserts.

Structure
REQ-024 FSM state encodings, NUM_REQ and MAX_TENURE defaults SHALL be defined as defines in the shared cache definition include file.
REQ-025 The round-robin priority encoder (request vector + rr_ptr -> winner, valid) SHALL be a separate combinational sub-module, rr_prio_enc_I.

Verification
REQ-026 Reset, then Req=0001 at edge 1 -> Gnt=0001 after edge 1, Gnt_id=0, Bus_busy=1.
REQ-027 Req=1111 held, each grantee drops after 3 grant cycles and re-raises -> grant order 0,1,2,3,0 with exactly one idle TURN cycle between grants.
REQ-028 Req0 held high forever, Req2 raised at grant cycle 5 -> Gnt0 revoked after 16 grant cycles, Tenure_expired=1 for one cycle, TURN, then Gnt=0100.
REQ-029 Req0 alone held 40 cycles -> Gnt0 continuous for 40 cycles, Tenure_expired never asserts.
REQ-030 rst_n pulsed low during Gnt=0010 -> Gnt=0000 within the same cycle; after release with Req=0010 -> Gnt=0010 one edge later, rr_ptr restarted at 0.
REQ-031 Every cycle of all tests: assert Gnt is one-hot or zero and Bus_busy equals OR(Gnt).

Source files
------------

// File: rtl/com_bus_arbiter_i_pkg.sv
// Shared definitions for the common instruction bus arbiter.
// Holds the FSM encoding and the parameter defaults.
package com_bus_arbiter_i_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_MAX_TENURE = 16;
  localparam int TEN_W          = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/com_bus_arbiter_i_rr_prio_enc.sv
// Round-robin priority encoder: first set request at or after ptr,
// wrapping from the top index back to zero.
module com_bus_arbiter_i_rr_prio_enc
  import com_bus_arbiter_i_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       valid
);

  localparam int IDW = $clog2(NUM_REQ);

  logic [IDW-1:0] idx;

  // Walk offsets high to low so the nearest hit overwrites the rest
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = IDW'((int'(ptr) + i) % NUM_REQ);
      if (req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/com_bus_arbiter_i.sv
// Common instruction bus arbiter: round-robin grant with a tenure
// limit and a one-cycle turnaround between grants.
module com_bus_arbiter_i
  import com_bus_arbiter_i_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int MAX_TENURE = DEF_MAX_TENURE
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         Com_Bus_Req_proc,
  output logic [NUM_REQ-1:0]         Com_Bus_Gnt_proc,
  output logic [$clog2(NUM_REQ)-1:0] Gnt_id,
  output logic                       Bus_busy,
  output logic                       Tenure_expired
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [TEN_W-1:0] TEN_MAX = TEN_W'(MAX_TENURE - 1);

  arb_state_e       state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   rr_q, rr_d;
  logic [TEN_W-1:0] cnt_q, cnt_d;
  logic             exp_q, exp_d;

  logic [IDW-1:0]   win;
  logic             win_vld;
  logic             own;
  logic             others;
  logic             sat;
  logic             rel;
  logic             rev;

  com_bus_arbiter_i_rr_prio_enc #(
    .NUM_REQ (NUM_REQ)
  ) u_enc (
    .req    (Com_Bus_Req_proc),
    .ptr    (rr_q),
    .winner (win),
    .valid  (win_vld)
  );

  assign own    = |(Com_Bus_Req_proc & gnt_q);
  assign others = |(Com_Bus_Req_proc & ~gnt_q);
  assign sat    = (cnt_q == TEN_MAX);
  assign rel    = !own;
  assign rev    = own && sat && others;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    exp_d   = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_TURN: begin
        gnt_d = '0;
        if (win_vld) begin
          state_d    = ST_GRANT;
          gnt_d[win] = 1'b1;
          id_d       = win;
          cnt_d      = '0;
          rr_d       = IDW'((int'(win) + 1) % NUM_REQ);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        // A release wins over expiry at the same edge
        unique case (1'b1)
          rel: begin
            state_d = ST_TURN;
            gnt_d   = '0;
          end
          rev: begin
            state_d = ST_TURN;
            gnt_d   = '0;
            exp_d   = 1'b1;
          end
          default: begin
            if (!sat) cnt_d = cnt_q + 1'b1;
          end
        endcase
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  assign Com_Bus_Gnt_proc = gnt_q;
  assign Gnt_id           = id_q;
  assign Bus_busy         = |gnt_q;
  assign Tenure_expired   = exp_q;

endmodule
